pie_tx_ctrl: RTL

PIE_TX_CTRL -- requirements
Module: pie_tx_ctrl

---
 rtl/pie_tx_ctrl_if.sv | 14 +
 rtl/pie_tx_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/pie_tx_ctrl_if.sv
// Command handshake bundle between a command source and the PIE transmit controller.
interface pie_tx_ctrl_if #(
    parameter int MAX_BITS = 32,
    parameter int LEN_W    = $clog2(MAX_BITS + 1)
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [MAX_BITS-1:0] cmd_data;
    logic [LEN_W-1:0]    cmd_len;
    logic                cmd_query;

    modport master (output cmd_valid, cmd_data, cmd_len, cmd_query, input cmd_ready);
    modport slave  (input cmd_valid, cmd_data, cmd_len, cmd_query, output cmd_ready);
endinterface

// File: rtl/pie_tx_ctrl.sv
// Sequences one PIE frame per command: carrier hold, MSB-first bit feed on encoder pulses, quiet gap.
// Accepts a command only in IDLE (cmd_ready low otherwise); CW starts the cycle after acceptance.
module pie_tx_ctrl #(
    parameter int MAX_BITS   = 32,
    parameter int LEN_W      = $clog2(MAX_BITS + 1),
    parameter int CW_CYCLES  = 16,
    parameter int GAP_CYCLES = 8
) (
    input  logic           clk,
    input  logic           rst,
    pie_tx_ctrl_if.slave   cmd,
    input  logic           abort,
    output logic           enc_rst,
    output logic           enc_bit,
    output logic           enc_preamble,
    input  logic           enc_rdy,
    output logic           busy,
    output logic           done,
    output logic           aborted,
    output logic           err_len
);
    localparam int CNT_MAX = (CW_CYCLES > GAP_CYCLES) ? CW_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, CW, SEND, DRAIN, GAP} state_t;

    state_t              state, state_nxt;
    logic [MAX_BITS-1:0] shift_reg;
    logic [LEN_W-1:0]    remaining;
    logic [CNT_W-1:0]    cnt;
    logic                accept, len_ok, frame_active;
    logic                done_nxt, aborted_nxt, err_nxt;

    assign cmd.cmd_ready = (state == IDLE) && !rst;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign len_ok        = (cmd.cmd_len != '0) && (cmd.cmd_len <= LEN_W'(MAX_BITS));
    assign frame_active  = (state == CW) || (state == SEND) || (state == DRAIN);
    assign busy          = (state != IDLE);
    assign enc_bit       = shift_reg[MAX_BITS-1];

    always_comb begin
        state_nxt   = state;
        done_nxt    = 1'b0;
        aborted_nxt = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (len_ok) state_nxt = CW;
                    else        err_nxt   = 1'b1;
                end
            end
            CW:    if (cnt == CNT_W'(CW_CYCLES - 1)) state_nxt = SEND;
            SEND:  if (enc_rdy && remaining == LEN_W'(1)) state_nxt = DRAIN;
            DRAIN: begin
                // This pulse closes the last symbol, not a new bit.
                if (enc_rdy) begin
                    state_nxt = GAP;
                    done_nxt  = 1'b1;
                end
            end
            GAP:   if (cnt == CNT_W'(GAP_CYCLES - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort wins over a coincident final enc_rdy.
        if (abort && frame_active) begin
            state_nxt   = GAP;
            done_nxt    = 1'b0;
            aborted_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            enc_rst      <= 1'b1;
            shift_reg    <= '0;
            remaining    <= '0;
            cnt          <= '0;
            enc_preamble <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            err_len      <= 1'b0;
        end else begin
            state   <= state_nxt;
            enc_rst <= !((state_nxt == SEND) || (state_nxt == DRAIN));
            done    <= done_nxt;
            aborted <= aborted_nxt;
            err_len <= err_nxt;

            if ((state_nxt != state) || !((state == CW) || (state == GAP)))
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);

            if (accept && len_ok) begin
                enc_preamble <= cmd.cmd_query;
                remaining    <= cmd.cmd_len;
                shift_reg    <= cmd.cmd_data << (LEN_W'(MAX_BITS) - cmd.cmd_len);
            end else if (state == SEND && enc_rdy) begin
                shift_reg <= {shift_reg[MAX_BITS-2:0], 1'b0};
                remaining <= remaining - LEN_W'(1);
            end
        end
    end
endmodule
